// File: rtl/mac_unit_if.sv
// Command/result bundle between the execute-stage controller (master) and mac_unit (slave).
interface mac_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [5:0]       Func;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;
  logic             OutValid;
  logic             C;
  logic             Z;
  logic             O;
  logic             N;

  modport master (
    output Start, Func, A, B, Flush,
    input  Ready, Busy, Done, Out, OutValid, C, Z, O, N
  );

  modport slave (
    input  Start, Func, A, B, Flush,
    output Ready, Busy, Done, Out, OutValid, C, Z, O, N
  );
endinterface

// File: rtl/mac_unit.sv
// Iterative multiply-accumulate unit owning the HI/LO accumulator.
// Retires STEP multiplier bits per cycle, then combines the product with HI/LO.
module mac_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic      Clock,
  input  logic      nReset,
  mac_unit_if.slave bus
);
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_MADD  = 6'h1C;
  localparam logic [5:0] FUNC_MADDU = 6'h1D;
  localparam logic [5:0] FUNC_MSUB  = 6'h1E;
  localparam logic [5:0] FUNC_MSUBU = 6'h1F;

  localparam int N_STEPS = WIDTH / STEP;
  localparam int CNT_W   = $clog2(N_STEPS) + 1;
  localparam int AW      = 2 * WIDTH;

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) || (WIDTH % STEP != 0)) begin : g_bad_param
    $error("mac_unit: STEP must be 1, 2, 4 or 8 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  function automatic logic is_mul_op(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_MADD) ||
           (f == FUNC_MADDU) || (f == FUNC_MSUB) || (f == FUNC_MSUBU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MADD) || (f == FUNC_MSUB);
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     mcand_q, mcand_d;
  logic [AW-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [5:0]        func_q, func_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              c_q, c_d, z_q, z_d, o_q, o_d, n_q, n_d;
  logic              done_q, done_d, out_valid_q, out_valid_d;

  logic              accept;
  logic              op_signed;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [AW-1:0]     partial, p_final;
  logic [AW:0]       sum_ext;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    mplier_d    = mplier_q;
    out_d       = out_q;
    func_d      = func_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    c_d         = c_q;
    z_d         = z_q;
    o_d         = o_q;
    n_d         = n_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    op_signed   = 1'b0;
    a_mag       = bus.A;
    b_mag       = bus.B;
    partial     = '0;
    p_final     = '0;
    sum_ext     = '0;
    accept      = bus.Start && (state_q == IDLE) && !bus.Flush;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.Func)
            FUNC_MTHI: acc_d[AW-1:WIDTH] = bus.A;
            FUNC_MTLO: acc_d[WIDTH-1:0]  = bus.A;
            FUNC_MFHI: begin
              out_d       = acc_q[AW-1:WIDTH];
              out_valid_d = 1'b1;
            end
            FUNC_MFLO: begin
              out_d       = acc_q[WIDTH-1:0];
              out_valid_d = 1'b1;
            end
            default: begin
              if (is_mul_op(bus.Func)) begin
                op_signed = is_signed_op(bus.Func);
                if (op_signed && bus.A[WIDTH-1]) a_mag = -bus.A;
                if (op_signed && bus.B[WIDTH-1]) b_mag = -bus.B;
                mcand_d  = {{WIDTH{1'b0}}, a_mag};
                mplier_d = b_mag;
                prod_d   = '0;
                func_d   = bus.Func;
                neg_d    = op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                cnt_d    = CNT_W'(N_STEPS - 1);
                state_d  = MUL;
              end
            end
          endcase
        end
      end

      MUL: begin
        if (bus.Flush) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < STEP; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
          end
          prod_d   = prod_q + partial;
          mcand_d  = mcand_q << STEP;
          mplier_d = mplier_q >> STEP;
          if (cnt_q == '0) state_d = FIN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
        if (!bus.Flush) begin
          op_signed = is_signed_op(func_q);
          p_final   = neg_q ? -prod_q : prod_q;
          case (func_q)
            FUNC_MADD, FUNC_MADDU: begin
              sum_ext = {1'b0, acc_q} + {1'b0, p_final};
              c_d     = sum_ext[AW];
              o_d     = op_signed ? ((acc_q[AW-1] == p_final[AW-1]) && (sum_ext[AW-1] != acc_q[AW-1]))
                                  : sum_ext[AW];
            end
            FUNC_MSUB, FUNC_MSUBU: begin
              // The extra top bit of the subtraction is the borrow (Acc < P unsigned).
              sum_ext = {1'b0, acc_q} - {1'b0, p_final};
              c_d     = sum_ext[AW];
              o_d     = op_signed ? ((acc_q[AW-1] != p_final[AW-1]) && (sum_ext[AW-1] != acc_q[AW-1]))
                                  : sum_ext[AW];
            end
            default: begin
              sum_ext = {1'b0, p_final};
              c_d     = 1'b0;
              o_d     = 1'b0;
            end
          endcase
          acc_d  = sum_ext[AW-1:0];
          z_d    = (acc_d == '0);
          n_d    = acc_d[AW-1];
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mplier_q    <= '0;
      out_q       <= '0;
      func_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      o_q         <= 1'b0;
      n_q         <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      mplier_q    <= mplier_d;
      out_q       <= out_d;
      func_q      <= func_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      c_q         <= c_d;
      z_q         <= z_d;
      o_q         <= o_d;
      n_q         <= n_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.Ready    = (state_q == IDLE);
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = done_q;
  assign bus.Out      = out_q;
  assign bus.OutValid = out_valid_q;
  assign bus.C        = c_q;
  assign bus.Z        = z_q;
  assign bus.O        = o_q;
  assign bus.N        = n_q;
endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: one task per scenario, hand-computed expectations.
module tb_mac_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MADD  = 6'h1C;
  localparam logic [5:0] F_MADDU = 6'h1D;
  localparam logic [5:0] F_MSUB  = 6'h1E;
  localparam logic [5:0] F_MSUBU = 6'h1F;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mac_unit_if #(.WIDTH(W)) bus();

  mac_unit #(.WIDTH(W), .STEP(4)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Holds Start until accepted, then returns at the negedge after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    bus.Start = 1'b1; bus.Func = f; bus.A = a; bus.B = b;
    while (bus.Ready !== 1'b1 && guard < 100) begin
      @(negedge Clock);
      guard++;
    end
    @(negedge Clock);
    bus.Start = 1'b0;
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("[TB] FAIL issue_ready: Ready=%b after %0d cycles, required 1", bus.Ready, guard);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (bus.Done !== 1'b1 && cycles < 60) begin
      @(negedge Clock);
      cycles++;
    end
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_timeout: Done=%b, required 1", bus.Done);
    end
  endtask

  task automatic read_reg(input logic [5:0] f, output logic [W-1:0] val, output logic vld);
    issue(f, '0, '0);
    val = bus.Out;
    vld = bus.OutValid;
  endtask

  task automatic test_reset;
    bus.Start = 1'b0; bus.Func = '0; bus.A = '0; bus.B = '0; bus.Flush = 1'b0;
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (bus.Ready !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_busy: got %b%b, required 10", bus.Ready, bus.Busy);
    end
    checks++;
    if (bus.Done !== 1'b0 || bus.OutValid !== 1'b0 || bus.Out !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: Done=%b OutValid=%b Out=%h, required 0 0 0", bus.Done, bus.OutValid, bus.Out);
    end
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: CZON=%b, required 0000", {bus.C, bus.Z, bus.O, bus.N});
    end
    nReset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_mult_signed;
    logic [W-1:0] v;
    logic vld;
    int cyc;
    issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mult_busy: Busy=%b Ready=%b, required 1 0", bus.Busy, bus.Ready);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 10) begin
      errors++; $display("[TB] FAIL mult_latency: Done in cycle %0d, required 10", cyc);
    end
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b0001 || bus.Ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mult_flags: CZON=%b Ready=%b, required 0001 1", {bus.C, bus.Z, bus.O, bus.N}, bus.Ready);
    end
    @(negedge Clock);
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++; $display("[TB] FAIL mult_done_pulse: Done=%b, required 0", bus.Done);
    end
    read_reg(F_MFHI, v, vld);
    checks++;
    if (v !== 32'hFFFF_FFFF || vld !== 1'b1 || bus.Done !== 1'b0) begin
      errors++; $display("[TB] FAIL mult_hi: Out=%h OutValid=%b Done=%b, required ffffffff 1 0", v, vld, bus.Done);
    end
    read_reg(F_MFLO, v, vld);
    checks++;
    if (v !== 32'hFFFF_FFEB || vld !== 1'b1) begin
      errors++; $display("[TB] FAIL mult_lo: Out=%h OutValid=%b, required ffffffeb 1", v, vld);
    end
    @(negedge Clock);
    checks++;
    if (bus.OutValid !== 1'b0) begin
      errors++; $display("[TB] FAIL outvalid_pulse: OutValid=%b, required 0", bus.OutValid);
    end
  endtask

  task automatic test_multu_zero;
    logic [W-1:0] hi, lo;
    logic vh, vl;
    int cyc;
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b0001) begin
      errors++; $display("[TB] FAIL multu_flags: CZON=%b, required 0001", {bus.C, bus.Z, bus.O, bus.N});
    end
    read_reg(F_MFHI, hi, vh);
    read_reg(F_MFLO, lo, vl);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("[TB] FAIL multu_acc: Acc=%h, required fffffffe00000001", {hi, lo});
    end
    issue(F_MULT, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    read_reg(F_MFHI, hi, vh);
    read_reg(F_MFLO, lo, vl);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("[TB] FAIL mult_minint: Acc=%h, required 0000000080000000", {hi, lo});
    end
    issue(F_MULT, 32'h0, 32'h1234_5678);
    wait_done(cyc);
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b0100) begin
      errors++; $display("[TB] FAIL mult_zero_flags: CZON=%b, required 0100", {bus.C, bus.Z, bus.O, bus.N});
    end
  endtask

  task automatic test_madd_overflow;
    logic [W-1:0] hi, lo;
    logic vh, vl;
    int cyc;
    issue(F_MTHI, 32'h7FFF_FFFF, '0);
    issue(F_MTLO, 32'hFFFF_FFFF, '0);
    issue(F_MADD, 32'd1, 32'd1);
    wait_done(cyc);
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b0011) begin
      errors++; $display("[TB] FAIL madd_flags: CZON=%b, required 0011", {bus.C, bus.Z, bus.O, bus.N});
    end
    read_reg(F_MFHI, hi, vh);
    read_reg(F_MFLO, lo, vl);
    checks++;
    if ({hi, lo} !== 64'h8000_0000_0000_0000) begin
      errors++; $display("[TB] FAIL madd_acc: Acc=%h, required 8000000000000000", {hi, lo});
    end
  endtask

  task automatic test_msub;
    logic [W-1:0] hi, lo;
    logic vh, vl;
    int cyc;
    issue(F_MTHI, '0, '0);
    issue(F_MTLO, '0, '0);
    issue(F_MSUBU, 32'd1, 32'd1);
    wait_done(cyc);
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b1011) begin
      errors++; $display("[TB] FAIL msubu_flags: CZON=%b, required 1011", {bus.C, bus.Z, bus.O, bus.N});
    end
    read_reg(F_MFHI, hi, vh);
    read_reg(F_MFLO, lo, vl);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL msubu_acc: Acc=%h, required ffffffffffffffff", {hi, lo});
    end
    issue(F_MTHI, '0, '0);
    issue(F_MTLO, '0, '0);
    issue(F_MSUB, 32'd1, 32'd1);
    wait_done(cyc);
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b1001) begin
      errors++; $display("[TB] FAIL msub_flags: CZON=%b, required 1001", {bus.C, bus.Z, bus.O, bus.N});
    end
    read_reg(F_MFLO, lo, vl);
    checks++;
    if (lo !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL msub_lo: Out=%h, required ffffffff", lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] hi, lo;
    logic vh, vl;
    int cyc;
    issue(F_MULTU, 32'd3, 32'd5);
    wait_done(cyc);
    issue(F_MADDU, 32'd2, 32'd2);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_accept: Busy=%b, required 1", bus.Busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 10) begin
      errors++; $display("[TB] FAIL b2b_latency: Done in cycle %0d, required 10", cyc);
    end
    read_reg(F_MFHI, hi, vh);
    read_reg(F_MFLO, lo, vl);
    checks++;
    if ({hi, lo} !== 64'd19) begin
      errors++; $display("[TB] FAIL b2b_acc: Acc=%h, required 0000000000000013", {hi, lo});
    end
  endtask

  task automatic test_busy_flush;
    logic [W-1:0] v;
    logic vld;
    logic saw_done;
    int cyc;
    issue(F_MULT, 32'hFFFF_FFFF, 32'd1);
    wait_done(cyc);
    issue(F_MTHI, 32'h0000_1111, '0);
    issue(F_MTLO, 32'h0000_2222, '0);
    checks++;
    if ({bus.C, bus.Z, bus.O, bus.N} !== 4'b0001) begin
      errors++; $display("[TB] FAIL move_flags: CZON=%b, required 0001", {bus.C, bus.Z, bus.O, bus.N});
    end
    issue(F_MULT, 32'd5, 32'd5);
    @(negedge Clock);
    bus.Start = 1'b1; bus.Func = F_MULTU; bus.A = 32'd7; bus.B = 32'd7;
    @(negedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    bus.Flush = 1'b1;
    @(negedge Clock);
    bus.Flush = 1'b0;
    checks++;
    if (bus.Ready !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_idle: Ready=%b Busy=%b Done=%b, required 1 0 0", bus.Ready, bus.Busy, bus.Done);
    end
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge Clock);
      if (bus.Done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || {bus.C, bus.Z, bus.O, bus.N} !== 4'b0001) begin
      errors++; $display("[TB] FAIL flush_no_done: saw Done=%b CZON=%b, required 0 0001", saw_done, {bus.C, bus.Z, bus.O, bus.N});
    end
    read_reg(F_MFHI, v, vld);
    checks++;
    if (v !== 32'h0000_1111) begin
      errors++; $display("[TB] FAIL flush_hi: Out=%h, required 00001111", v);
    end
    read_reg(F_MFLO, v, vld);
    checks++;
    if (v !== 32'h0000_2222) begin
      errors++; $display("[TB] FAIL flush_lo: Out=%h, required 00002222", v);
    end
    bus.Start = 1'b1; bus.Func = F_MTHI; bus.A = 32'hDEAD; bus.Flush = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    read_reg(F_MFHI, v, vld);
    checks++;
    if (v !== 32'h0000_1111) begin
      errors++; $display("[TB] FAIL flush_drop_start: Out=%h, required 00001111", v);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [W-1:0] v;
    logic vld;
    issue(F_MTHI, 32'h0000_1234, '0);
    issue(F_MULT, 32'd3, 32'd3);
    repeat (3) @(negedge Clock);
    nReset = 1'b0;
    #1;
    checks++;
    if (bus.Ready !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_state: Ready=%b Busy=%b Done=%b, required 1 0 0", bus.Ready, bus.Busy, bus.Done);
    end
    checks++;
    if (bus.Out !== '0 || bus.OutValid !== 1'b0 || {bus.C, bus.Z, bus.O, bus.N} !== 4'b0000) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: Out=%h OutValid=%b CZON=%b, required 0 0 0000", bus.Out, bus.OutValid, {bus.C, bus.Z, bus.O, bus.N});
    end
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    read_reg(F_MFHI, v, vld);
    checks++;
    if (v !== '0 || vld !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_hi: Out=%h OutValid=%b, required 00000000 1", v, vld);
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_zero();
    test_madd_overflow();
    test_msub();
    test_back_to_back();
    test_busy_flush();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_unit.md
# mac_unit

Parametrised iterative multiply-accumulate unit for the execute stage. It owns the HI/LO accumulator and computes signed and unsigned products over several cycles, STEP multiplier bits per cycle, with a Ready/Busy handshake. It also performs accumulate/subtract into HI/LO and single-cycle HI/LO moves, and reports registered C/Z/O/N flags. The pipeline controller stalls on Busy and may abort an in-flight operation with Flush.

## Interface
- WIDTH, 32: operand width. The accumulator is 2*WIDTH bits; HI = Acc[2W-1:W], LO = Acc[W-1:0].
- STEP, 4: multiplier bits retired per cycle.
  - Legal values: 1, 2, 4, 8.
  - WIDTH % STEP must be 0; elaboration error otherwise.
  - N = WIDTH/STEP.
- Clock  in  1  clock, rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- Start  in  1  command valid.
- Func  in  6  operation code from mul_definition.sv: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MFHI, MFLO, MTHI, MTLO.
- A  in  WIDTH  multiplicand, or MTHI/MTLO source.
- B  in  WIDTH  multiplier.
- Flush  in  1  abort the in-flight multiply.
- Ready  out  1  command accepted this cycle if Start=1. Ready = ~Busy.
- Busy  out  1  multi-cycle operation in progress.
- Done  out  1  one-cycle pulse: multiply-class result committed.
- Out  out  WIDTH  registered MFHI/MFLO result.
- OutValid  out  1  one-cycle pulse with Out.
- C, Z, O, N  out  1 each  registered carry/borrow, zero, overflow and negative flags.

## Operation
- Acceptance: a command is accepted when Start & Ready & ~Flush.
  - Start while Busy is ignored. The requester holds Start until Ready.
  - Unknown Func codes are accepted and cause no state change.
- States:
  - IDLE: Ready=1. Accepting a multiply-class Func moves to MUL and captures A, B, Func, and the operand signs.
  - MUL: N cycles.
    - Each cycle adds the shifted magnitude of A for STEP bits of |B|, into a 2W-bit partial product.
    - Signed ops (MULT, MADD, MSUB) use two's-complement magnitudes; the product is negated at the end if sign(A) ^ sign(B).
  - FIN: one cycle. Combines the product P with Acc, then returns to IDLE.
- Multiply-class results:
  - MULT, MULTU: Acc = P. C=0, O=0.
  - MADD, MADDU: {C, Acc} = Acc + P.
  - MSUB, MSUBU: {C, Acc} = Acc - P, where C is the borrow (Acc < P unsigned).
- Overflow flag:
  - Signed add: O=1 when Acc and P have the same sign and the result sign differs.
  - Signed subtract: O=1 when Acc and P have differing signs and the result sign differs from Acc.
  - Unsigned: O = C.
- Z and N are recomputed from the new Acc: Z = (Acc == 0), N = Acc[2W-1].
- Flags change only at a multiply-class commit. They are unaffected by move instructions.
- Moves (IDLE only, no Busy):
  - MTHI writes HI = A; MTLO writes LO = A; each at the accept edge.
  - MFHI/MFLO register Out = HI or LO, with OutValid=1 the next cycle.
- Flush:
  - In MUL or FIN: aborts. Acc and flags are unchanged, there is no Done, and the next state is IDLE.
  - In IDLE: drops a simultaneous Start.
- Reset: an asynchronous nReset forces the following, from any state including mid-MUL:
  - state = IDLE
  - Acc = 0
  - C = Z = O = N = 0
  - Out = 0, OutValid = 0, Done = 0, Busy = 0, Ready = 1

## Timing
- Multiply-class commands:
  - Start is accepted at edge E0. Busy = 1 from after E0 through edge E0+N+1.
  - Acc, flags, Done=1 and Ready=1 are visible in the cycle after edge E0+N+1.
  - Latency is N+1 cycles. With the defaults that is 9 cycles, and Done is high in the 10th cycle counted from the Start cycle.
  - Back-to-back: a new Start is accepted in the Done cycle.
- MTHI/MTLO: take effect at the accept edge. An MFHI/MFLO issued in the next cycle reads the new value.
- MFHI/MFLO: Out and OutValid one cycle after acceptance. Issued during Busy, they wait (Ready=0) and return the committed result.
- Done and OutValid are single-cycle pulses and are never high together.

## Test plan
- MULT, A=0xFFFFFFFD (-3), B=7 -> Done after 9 cycles; MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB; N=1, Z=0, C=0, O=0.
- MULTU, A=B=0xFFFFFFFF -> Acc=0xFFFFFFFE_00000001; then MULT with A=0 -> Z=1, N=0.
- MTHI 0x7FFFFFFF, MTLO 0xFFFFFFFF, MADD A=1, B=1 -> Acc=0x80000000_00000000; O=1, N=1, C=0, Z=0.
- MTHI 0, MTLO 0, MSUBU A=1, B=1 -> Acc=0xFFFFFFFF_FFFFFFFF; C=1, O=1, N=1. MSUB with the same setup -> same Acc, C=1, O=0.
- MULT started, Start re-asserted during Busy (ignored), Flush in MUL cycle 4 -> no Done, Acc and flags unchanged, Ready=1 next cycle.
- nReset asserted mid-MUL after MTHI 0x1234 -> all outputs at reset values; MFHI then returns 0 with OutValid one cycle later.
